muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath, directly downstream of the register file: it consumes the two read ports (rs, rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the architectural HI/LO pair. The writeback path reads HI/LO for MFHI/MFLO. Control stalls issue while `busy` is high.

## Interface
- XLEN, 32, operand/result width (fixed; no other value supported)
- clk  in  1  system clock, all state on rising edge
- res  in  1  reset, asynchronous, active-low
- start  in  1  request a mult/div operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- mthi  in  1  write rs_val to HI (IDLE only)
- mtlo  in  1  write rs_val to LO (IDLE only)
- rs_val  in  32  operand A / dividend (register-file dout1)
- rt_val  in  32  operand B / divisor (register-file dout2)
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse: HI/LO hold a new mult/div result
- div_zero  out  1  qualifies done: last DIV/DIVU had rt_val = 0; held until next accepted start
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE + start: latch |rs|, |rt| (signed ops) or raw values (unsigned), result-sign bits, op; count <= 0; clear div_zero. → CALC, except DIV/DIVU with rt_val = 0 → FIX.
- CALC: one iteration per cycle, count 0..31. Multiply: shift-add into a 64-bit accumulator. Divide: restoring, one quotient bit per cycle, 33-bit partial remainder. count = 31 → FIX.
- FIX: conditional two's-complement negate; write hi/lo; set done; → IDLE.
- Multiply result: {hi, lo} = 64-bit product; negated when exactly one operand is negative (signed only).
- Divide result: lo = quotient, hi = remainder. Signed: quotient negative if operand signs differ; remainder takes dividend's sign.
- Divide by zero: hi = rs_val, lo = 0xFFFFFFFF, div_zero = 1.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (natural wrap; no flag).
- mthi/mtlo: honoured only in IDLE with start low; both may be asserted in the same cycle. start with mthi/mtlo in the same cycle: start wins, the move is dropped. Either in CALC/FIX: ignored.
- start while busy: ignored; no queuing.
- Reset (any state, including mid-CALC): state IDLE, hi = lo = 0, busy = done = div_zero = 0, count = 0.

## Timing
- Accept edge E0 (IDLE, start = 1). busy is high from after E0 through the cycle before E33.
- CALC occupies edges E1..E32. FIX at E33 writes hi/lo and raises done. done is high for exactly the cycle after E33 and clears at E34.
- Mult/div latency: start edge to hi/lo valid is 33 edges. Divide by zero: FIX at E1, valid after E1.
- hi/lo keep their old values throughout CALC. They change only at FIX, at an accepted mthi/mtlo, or at reset.
- Back-to-back: start is accepted in the cycle done is high, because the state is IDLE.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package muldiv_pkg: XLEN, op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum (IDLE, CALC, FIX), DIV0_LO constant 0xFFFFFFFF.
- One sub-module, muldiv_neg: combinational conditional two's complement, parameterised width. It is used for operand magnitudes (32-bit) and for the FIX sign correction (64-bit, and 32-bit ×2).
- The rest of the design is one FSM plus a shared 64-bit shift register for the multiply accumulator and the remainder/quotient.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001; done exactly 34 cycles after the cycle start was high; busy high 33 cycles.
- MULT 0xFFFFFFFD (-3) × 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- DIV -7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 100 / 7 → lo = 14, hi = 2.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIV rs = 0x1234, rt = 0 → done in the cycle after E1, div_zero = 1, hi = 0x1234, lo = 0xFFFFFFFF. A following MULT clears div_zero at accept.
- Ignored and pre-empted inputs:
  - start and mthi (rs = 0xAAAA5555) asserted at count = 10: both ignored; result unchanged.
  - Then drop res at count = 20: all outputs read 0 immediately (asynchronously).
  - After reset, mtlo with rs = 0x55 → lo = 0x55 next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

endpackage

// File: rtl/muldiv_neg.sv
// Conditional two's-complement negate of a W-bit value.
module muldiv_neg #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? ((~i_val) + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit holding the HI/LO pair.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            res,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_t            r_state;
    state_t            w_next;
    logic [4:0]        r_cnt;
    logic [63:0]       r_acc;
    logic [XLEN-1:0]   r_opb;
    logic              r_div;
    logic              r_dz;
    logic              r_neg_lo;
    logic              r_neg_hi;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic              r_done;
    logic              r_div_zero;
    logic              w_busy;

    logic              w_signed;
    logic              w_sa;
    logic              w_sb;
    logic              w_rt_zero;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [32:0]       w_sum;
    logic [32:0]       w_trial;
    logic [63:0]       w_step;
    logic [63:0]       w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    assign w_signed  = ~op[0];
    assign w_sa      = w_signed & rs_val[XLEN-1];
    assign w_sb      = w_signed & rt_val[XLEN-1];
    assign w_rt_zero = (rt_val == '0);

    muldiv_neg #(.W(XLEN)) u_abs_a (
        .i_neg(w_sa), .i_val(rs_val), .o_val(w_abs_a)
    );
    muldiv_neg #(.W(XLEN)) u_abs_b (
        .i_neg(w_sb), .i_val(rt_val), .o_val(w_abs_b)
    );
    muldiv_neg #(.W(64)) u_fix_p (
        .i_neg(r_neg_lo), .i_val(r_acc), .o_val(w_prod)
    );
    muldiv_neg #(.W(XLEN)) u_fix_q (
        .i_neg(r_neg_lo), .i_val(r_acc[31:0]), .o_val(w_quo)
    );
    muldiv_neg #(.W(XLEN)) u_fix_r (
        .i_neg(r_neg_hi), .i_val(r_acc[63:32]), .o_val(w_rem)
    );

    // Shared register: product {hi,lo} for mult, {remainder,quotient} for div.
    assign w_sum   = {1'b0, r_acc[63:32]} + {1'b0, r_opb};
    assign w_trial = r_acc[63:31] - {1'b0, r_opb};

    always_comb begin
        w_step = r_acc;
        if (r_div) begin
            if (w_trial[32])
                w_step = {r_acc[62:0], 1'b0};
            else
                w_step = {w_trial[31:0], r_acc[30:0], 1'b1};
        end else begin
            if (r_acc[0])
                w_step = {w_sum, r_acc[31:1]};
            else
                w_step = {1'b0, r_acc[63:1]};
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (start) w_next = (op[1] & w_rt_zero) ? FIX : CALC;
            CALC: if (r_cnt == 5'd31) w_next = FIX;
            FIX:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opb      <= '0;
            r_div      <= 1'b0;
            r_dz       <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt      <= '0;
                        r_div_zero <= 1'b0;
                        r_div      <= op[1];
                        r_dz       <= op[1] & w_rt_zero;
                        r_opb      <= w_abs_b;
                        r_neg_lo   <= w_sa ^ w_sb;
                        r_neg_hi   <= w_sa;
                        r_acc      <= {32'b0, (op[1] & w_rt_zero) ? rs_val : w_abs_a};
                    end else begin
                        if (mthi) r_hi <= rs_val;
                        if (mtlo) r_lo <= rs_val;
                    end
                end
                CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 5'd1;
                end
                FIX: begin
                    r_done <= 1'b1;
                    if (r_dz) begin
                        r_hi       <= r_acc[31:0];
                        r_lo       <= DIV0_LO;
                        r_div_zero <= 1'b1;
                    end else if (r_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = w_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus random checks of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;

    logic        clk;
    logic        res;
    logic        start;
    logic [1:0]  op;
    logic        mthi;
    logic        mtlo;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int t_start;
    int bcnt;
    logic [64:0] exp_r;
    logic [31:0] old_hi;
    logic [31:0] old_lo;

    muldiv_unit dut (
        .clk(clk), .res(res), .start(start), .op(op),
        .mthi(mthi), .mtlo(mtlo), .rs_val(rs_val), .rt_val(rt_val),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {div_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] ref_op(input logic [1:0] o,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 2'b00) begin
            p = sa * sb;
            return {1'b0, p};
        end
        if (o == 2'b01) begin
            p = {32'h0, a} * {32'h0, b};
            return {1'b0, p};
        end
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == 2'b11) begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        nchk++;
        assert (got === want) else begin
            nerr++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Caller is at a negedge; start is sampled at the next posedge.
    task automatic fire(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
        op      = o;
        rs_val  = a;
        rt_val  = b;
        start   = 1'b1;
        exp_r   = ref_op(o, a, b);
        t_start = cyc;
        old_hi  = hi;
        old_lo  = lo;
        @(negedge clk);
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        bcnt   = busy ? 1 : 0;
        chk("dz_clear", {63'b0, div_zero}, 64'd0);
        chk("hold", {hi, lo}, {old_hi, old_lo});
    endtask

    task automatic finish_op(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            if (busy) bcnt++;
            n++;
        end
        chk({tag, "_done"}, {63'b0, done}, 64'd1);
        chk({tag, "_lat"}, 64'(cyc - t_start), exp_r[64] ? 64'd2 : 64'd34);
        chk({tag, "_busy"}, 64'(bcnt), exp_r[64] ? 64'd1 : 64'd33);
        chk({tag, "_hi"}, {32'h0, hi}, {32'h0, exp_r[63:32]});
        chk({tag, "_lo"}, {32'h0, lo}, {32'h0, exp_r[31:0]});
        chk({tag, "_dz"}, {63'b0, div_zero}, {63'b0, exp_r[64]});
    endtask

    task automatic do_op(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        fire(o, a, b);
        finish_op(tag);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        res = 1'b0; start = 1'b0; op = 2'b00;
        mthi = 1'b0; mtlo = 1'b0; rs_val = '0; rt_val = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_dz", {63'b0, div_zero}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        res = 1'b1;

        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; rs_val = 32'hCAFE_BABE;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mv_both", {hi, lo}, {32'hCAFE_BABE, 32'hCAFE_BABE});

        @(negedge clk);
        mthi = 1'b1;
        fire(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mthi = 1'b0;
        finish_op("multu_max");
        do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7);
        do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
        do_op("divu", 2'b11, 32'd100, 32'd7);
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("div_zero", 2'b10, 32'h0000_1234, 32'h0);
        do_op("mult_after", 2'b00, 32'h8000_0000, 32'h8000_0000);
        do_op("divu_zero", 2'b11, 32'h8765_4321, 32'h0);
        do_op("div_rem", 2'b10, 32'd13, 32'hFFFF_FFFC);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 999)) :
                 $urandom;
            do_op("rand", ro, ra, rb);
        end

        fire(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        start = 1'b1; mthi = 1'b1; op = 2'b11; rs_val = 32'hAAAA_5555;
        @(negedge clk);
        if (busy) bcnt++;
        start = 1'b0; mthi = 1'b0;
        chk("ign_hold", {hi, lo}, {old_hi, old_lo});
        finish_op("ignored");

        fire(2'b11, $urandom, 32'd3);
        repeat (19) @(negedge clk);
        res = 1'b0;
        #1;
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_done", {63'b0, done}, 64'd0);
        chk("arst_dz", {63'b0, div_zero}, 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        mtlo = 1'b1; rs_val = 32'h55;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_lo", {32'h0, lo}, 64'h55);
        chk("mtlo_hi", {32'h0, hi}, 64'h0);
        do_op("recover", 2'b00, 32'hFFFF_FFFF, 32'h0000_0005);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
